// File: rtl/mem_pkg.sv
// Shared definitions for the memory burst responder: direction encoding,
// burst geometry and FSM state encoding.
package mem_pkg;

    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    localparam int BURST_LEN = 4;
    localparam int LINE_BITS = 2;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        RBEAT,
        RGAP,
        WBEAT
    } state_t;

endpackage

// File: rtl/mem_word_ram.sv
// Word-addressed backing store. Synchronous write, combinational read.
// The memory array has no reset, so its contents survive a logic reset.
module mem_word_ram #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WIDTH = 12
) (
    input  logic                   clk_i,
    input  logic                   we_i,
    input  logic [DEPTH_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0]  wdata_i,
    output logic [DATA_WIDTH-1:0]  rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [2**DEPTH_WIDTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_burst_responder.sv
// Memory endpoint for D-cache line transfers. After a programmable latency it
// answers each request with a 4-beat burst; read beats may be spaced by gap cycles.
module mem_burst_responder
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDRESS_WIDTH   = 22,
    parameter int MEM_DEPTH_WIDTH = 12,
    parameter int LATENCY         = 2,
    parameter int BEAT_GAP        = 0
) (
    input  logic                     i_Clk,
    input  logic                     i_Reset_n,
    input  logic                     i_MEM_Valid,
    input  logic                     i_MEM_Read_Write_n,
    input  logic [ADDRESS_WIDTH-1:0] i_MEM_Address,
    input  logic [DATA_WIDTH-1:0]    i_MEM_Data,
    output logic                     o_MEM_Valid,
    output logic                     o_MEM_Data_Read,
    output logic                     o_MEM_Last,
    output logic [DATA_WIDTH-1:0]    o_MEM_Data,
    output logic                     o_Busy
);

    localparam int LAT_W = $clog2(LATENCY + 1);
    localparam int GAP_W = (BEAT_GAP > 0) ? $clog2(BEAT_GAP + 1) : 1;
    localparam int IDX_W = MEM_DEPTH_WIDTH - LINE_BITS;
    localparam logic [LINE_BITS-1:0] LAST_BEAT = LINE_BITS'(BURST_LEN - 1);

    state_t                 state_q;
    logic [LAT_W-1:0]       lat_q;
    logic [GAP_W-1:0]       gap_q;
    logic [LINE_BITS-1:0]   beat_q;
    logic [IDX_W-1:0]       line_q;
    logic                   dir_q;
    logic                   valid_q;
    logic                   dread_q;
    logic                   last_q;
    logic                   busy_q;
    logic [DATA_WIDTH-1:0]  data_q;

    logic [MEM_DEPTH_WIDTH-1:0] ram_addr_d;
    logic                       ram_we_d;
    logic [DATA_WIDTH-1:0]      ram_rdata;
    logic                       unused_addr;

    // Line base has its low word bits zero, so base+beat is a simple concatenation;
    // address bits above the store depth alias silently.
    assign ram_addr_d  = {line_q, beat_q};
    assign ram_we_d    = (state_q == WBEAT);
    assign unused_addr = ^{i_MEM_Address[ADDRESS_WIDTH-1:MEM_DEPTH_WIDTH+1],
                           i_MEM_Address[LINE_BITS:0]};

    mem_word_ram #(
        .DATA_WIDTH  (DATA_WIDTH),
        .DEPTH_WIDTH (MEM_DEPTH_WIDTH)
    ) u_ram (
        .clk_i   (i_Clk),
        .we_i    (ram_we_d),
        .addr_i  (ram_addr_d),
        .wdata_i (i_MEM_Data),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q <= IDLE;
            lat_q   <= '0;
            gap_q   <= '0;
            beat_q  <= '0;
            line_q  <= '0;
            dir_q   <= WRITE;
            valid_q <= 1'b0;
            dread_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_MEM_Valid) begin
                        state_q <= WAIT;
                        lat_q   <= LAT_W'(LATENCY);
                        beat_q  <= '0;
                        line_q  <= i_MEM_Address[MEM_DEPTH_WIDTH:LINE_BITS+1];
                        dir_q   <= i_MEM_Read_Write_n;
                        busy_q  <= 1'b1;
                    end
                end
                WAIT: begin
                    if (lat_q == LAT_W'(1)) begin
                        case (dir_q)
                            READ: begin
                                state_q <= RBEAT;
                                valid_q <= 1'b1;
                                data_q  <= ram_rdata;
                                last_q  <= (beat_q == LAST_BEAT);
                                beat_q  <= beat_q + 1'b1;
                            end
                            WRITE: begin
                                state_q <= WBEAT;
                                dread_q <= 1'b1;
                                last_q  <= 1'b0;
                            end
                        endcase
                    end else begin
                        lat_q <= lat_q - LAT_W'(1);
                    end
                end
                RBEAT: begin
                    // beat_q already points at the next beat to present.
                    if (last_q) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (BEAT_GAP > 0) begin
                        state_q <= RGAP;
                        gap_q   <= GAP_W'(BEAT_GAP);
                        valid_q <= 1'b0;
                    end else begin
                        data_q  <= ram_rdata;
                        last_q  <= (beat_q == LAST_BEAT);
                        beat_q  <= beat_q + 1'b1;
                    end
                end
                RGAP: begin
                    if (gap_q == GAP_W'(1)) begin
                        state_q <= RBEAT;
                        valid_q <= 1'b1;
                        data_q  <= ram_rdata;
                        last_q  <= (beat_q == LAST_BEAT);
                        beat_q  <= beat_q + 1'b1;
                    end else begin
                        gap_q <= gap_q - GAP_W'(1);
                    end
                end
                WBEAT: begin
                    if (last_q) begin
                        state_q <= IDLE;
                        dread_q <= 1'b0;
                        last_q  <= 1'b0;
                        busy_q  <= 1'b0;
                    end else begin
                        last_q <= ((beat_q + 1'b1) == LAST_BEAT);
                        beat_q <= beat_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_MEM_Valid     = valid_q;
    assign o_MEM_Data_Read = dread_q;
    assign o_MEM_Last      = last_q;
    assign o_MEM_Data      = data_q;
    assign o_Busy          = busy_q;

endmodule

// File: tb/tb_mem_burst_responder.sv
// Bench for mem_burst_responder: two instances (beat gap 0 and 2) share stimulus;
// a scoreboard queues expected beats per instance and a monitor checks them.
module tb_mem_burst_responder;
    import mem_pkg::*;

    localparam int DW  = 32;
    localparam int AW  = 22;
    localparam int MDW = 12;
    localparam int LAT = 2;

    typedef struct {
        int            cyc;
        logic [DW-1:0] dat;
        logic          last;
    } exp_t;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          vld_i = 1'b0;
    logic          rw_i  = 1'b0;
    logic [AW-1:0] addr_i = '0;
    logic [DW-1:0] wdat_i = '0;

    logic [1:0]    vld_o;
    logic [1:0]    drd_o;
    logic [1:0]    last_o;
    logic [1:0]    busy_o;
    logic [DW-1:0] dat_o [2];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    exp_t          rq [2][$];
    exp_t          wq [2][$];
    logic [DW-1:0] model [int];
    logic [DW-1:0] wbuf [4];
    int            widx = 0;
    logic          adv  = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_burst_responder #(
        .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MEM_DEPTH_WIDTH(MDW),
        .LATENCY(LAT), .BEAT_GAP(0)
    ) u_dut0 (
        .i_Clk(clk), .i_Reset_n(rst_n), .i_MEM_Valid(vld_i),
        .i_MEM_Read_Write_n(rw_i), .i_MEM_Address(addr_i), .i_MEM_Data(wdat_i),
        .o_MEM_Valid(vld_o[0]), .o_MEM_Data_Read(drd_o[0]), .o_MEM_Last(last_o[0]),
        .o_MEM_Data(dat_o[0]), .o_Busy(busy_o[0])
    );

    mem_burst_responder #(
        .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MEM_DEPTH_WIDTH(MDW),
        .LATENCY(LAT), .BEAT_GAP(2)
    ) u_dut2 (
        .i_Clk(clk), .i_Reset_n(rst_n), .i_MEM_Valid(vld_i),
        .i_MEM_Read_Write_n(rw_i), .i_MEM_Address(addr_i), .i_MEM_Data(wdat_i),
        .o_MEM_Valid(vld_o[1]), .o_MEM_Data_Read(drd_o[1]), .o_MEM_Last(last_o[1]),
        .o_MEM_Data(dat_o[1]), .o_Busy(busy_o[1])
    );

    function automatic int gap_of(int inst);
        return (inst == 0) ? 0 : 2;
    endfunction

    function automatic int sidx(logic [AW-1:0] a, int k);
        int w;
        w = int'(a >> 1) & ~3;
        return (w + k) & ((1 << MDW) - 1);
    endfunction

    function automatic logic [DW-1:0] model_rd(int idx);
        return model.exists(idx) ? model[idx] : '0;
    endfunction

    function automatic int pend();
        return rq[0].size() + rq[1].size() + wq[0].size() + wq[1].size();
    endfunction

    // Cache-side write data: advance one word after each consumed beat.
    always @(negedge clk) adv = drd_o[0];
    always @(posedge clk) begin
        #1;
        if (adv && widx < 3) begin
            widx++;
            wdat_i = wbuf[widx];
        end
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            if (vld_o[i]) begin
                n_cmp++;
                if (rq[i].size() == 0) begin
                    n_err++;
                    $display("FAIL rd_unexpected inst%0d cyc=%0d data=%h, required no read beat", i, cyc, dat_o[i]);
                end else begin
                    e = rq[i].pop_front();
                    if (cyc !== e.cyc || dat_o[i] !== e.dat || last_o[i] !== e.last) begin
                        n_err++;
                        $display("FAIL rd_beat inst%0d got cyc=%0d data=%h last=%b, required cyc=%0d data=%h last=%b",
                                 i, cyc, dat_o[i], last_o[i], e.cyc, e.dat, e.last);
                    end
                end
            end
            if (drd_o[i]) begin
                n_cmp++;
                if (wq[i].size() == 0) begin
                    n_err++;
                    $display("FAIL wr_unexpected inst%0d cyc=%0d, required no write beat", i, cyc);
                end else begin
                    e = wq[i].pop_front();
                    if (cyc !== e.cyc || last_o[i] !== e.last) begin
                        n_err++;
                        $display("FAIL wr_beat inst%0d got cyc=%0d last=%b, required cyc=%0d last=%b",
                                 i, cyc, last_o[i], e.cyc, e.last);
                    end
                end
            end
            if (last_o[i] && !vld_o[i] && !drd_o[i]) begin
                n_cmp++;
                n_err++;
                $display("FAIL last_alone inst%0d cyc=%0d, required Last only with a beat", i, cyc);
            end
        end
    end

    task automatic push_reads(logic [AW-1:0] a, int ca);
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 4; k++) begin
                e.cyc  = ca + LAT + k * (gap_of(i) + 1);
                e.dat  = model_rd(sidx(a, k));
                e.last = (k == 3);
                rq[i].push_back(e);
            end
        end
    endtask

    task automatic do_req(bit rd, logic [AW-1:0] a, int nbeats, bit hold, output int ca);
        exp_t e;
        if (!rd) begin
            widx   = 0;
            wdat_i = wbuf[0];
        end
        vld_i  = 1'b1;
        rw_i   = rd ? READ : WRITE;
        addr_i = a;
        @(posedge clk);
        #1;
        ca = cyc;
        if (!hold) begin
            vld_i  = 1'b0;
            rw_i   = ~rw_i;
            addr_i = AW'($urandom);
        end
        if (rd) begin
            push_reads(a, ca);
        end else begin
            for (int i = 0; i < 2; i++) begin
                for (int k = 0; k < nbeats; k++) begin
                    e.cyc  = ca + LAT + k;
                    e.dat  = '0;
                    e.last = (k == 3);
                    wq[i].push_back(e);
                end
            end
            for (int k = 0; k < nbeats; k++) model[sidx(a, k)] = wbuf[k];
        end
    endtask

    task automatic wait_idle(output bit ok);
        int n = 0;
        while (busy_o != 2'b00 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        ok = (busy_o == 2'b00);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (vld_o !== 2'b00)  begin n_err++; $display("FAIL reset_valid got %b required 00", vld_o); end
        n_cmp++; if (drd_o !== 2'b00)  begin n_err++; $display("FAIL reset_dread got %b required 00", drd_o); end
        n_cmp++; if (last_o !== 2'b00) begin n_err++; $display("FAIL reset_last got %b required 00", last_o); end
        n_cmp++; if (busy_o !== 2'b00) begin n_err++; $display("FAIL reset_busy got %b required 00", busy_o); end
        n_cmp++; if (dat_o[0] !== '0 || dat_o[1] !== '0) begin
            n_err++; $display("FAIL reset_data got %h/%h required 0", dat_o[0], dat_o[1]);
        end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_write();
        int ca; bit ok;
        wbuf = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        do_req(1'b0, 22'h000010, 4, 1'b0, ca);
        wait_idle(ok);
        n_cmp++; if (!ok || pend() != 0) begin
            n_err++; $display("FAIL write_drain busy=%b pending=%0d required idle, 0 pending", busy_o, pend());
        end
    endtask

    task automatic test_read();
        int ca; bit ok;
        do_req(1'b1, 22'h000010, 4, 1'b0, ca);
        repeat (LAT + 4) @(posedge clk);
        #1;
        n_cmp++; if (busy_o !== 2'b10) begin
            n_err++; $display("FAIL read_busy_after_last got %b required 10", busy_o);
        end
        wait_idle(ok);
        n_cmp++; if (!ok || pend() != 0) begin
            n_err++; $display("FAIL read_drain busy=%b pending=%0d required idle, 0 pending", busy_o, pend());
        end
    endtask

    task automatic test_back_to_back();
        int ca; int ca2; bit ok;
        wbuf = '{32'hB0, 32'hB1, 32'hB2, 32'hB3};
        do_req(1'b0, 22'h000020, 4, 1'b1, ca);
        repeat (LAT + 3) @(posedge clk);
        #1;
        rw_i = READ;
        repeat (2) @(posedge clk);
        #1;
        ca2   = cyc;
        vld_i = 1'b0;
        push_reads(22'h000020, ca2);
        n_cmp++; if (busy_o !== 2'b11) begin
            n_err++; $display("FAIL b2b_accept busy=%b required 11", busy_o);
        end
        wait_idle(ok);
        n_cmp++; if (!ok || pend() != 0) begin
            n_err++; $display("FAIL b2b_drain busy=%b pending=%0d required idle, 0 pending", busy_o, pend());
        end
    endtask

    task automatic test_beat_gap();
        int ca; bit ok; logic [1:0] want;
        do_req(1'b1, 22'h000010, 4, 1'b0, ca);
        for (int n = 0; n <= 13; n++) begin
            want[0] = (n >= LAT) && (n < LAT + 4);
            want[1] = (n >= LAT) && ((n - LAT) % 3 == 0) && ((n - LAT) / 3 < 4);
            n_cmp++; if (vld_o !== want) begin
                n_err++; $display("FAIL gap_valid_pattern n=%0d got %b required %b", n, vld_o, want);
            end
            @(posedge clk);
            #1;
        end
        wait_idle(ok);
        n_cmp++; if (!ok || pend() != 0) begin
            n_err++; $display("FAIL gap_drain busy=%b pending=%0d required idle, 0 pending", busy_o, pend());
        end
    endtask

    task automatic test_reset_mid_write();
        int ca; bit ok;
        wbuf = '{32'hC0, 32'hC1, 32'hC2, 32'hC3};
        do_req(1'b0, 22'h000030, 2, 1'b0, ca);
        repeat (LAT + 2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (vld_o !== 2'b00 || drd_o !== 2'b00 || last_o !== 2'b00 || busy_o !== 2'b00) begin
            n_err++; $display("FAIL midreset_outputs vld=%b drd=%b last=%b busy=%b required all 0",
                              vld_o, drd_o, last_o, busy_o);
        end
        n_cmp++; if (dat_o[0] !== '0 || dat_o[1] !== '0) begin
            n_err++; $display("FAIL midreset_data got %h/%h required 0", dat_o[0], dat_o[1]);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_req(1'b1, 22'h000030, 4, 1'b0, ca);
        wait_idle(ok);
        n_cmp++; if (!ok || pend() != 0) begin
            n_err++; $display("FAIL midreset_drain busy=%b pending=%0d required idle, 0 pending", busy_o, pend());
        end
    endtask

    task automatic test_alias();
        int ca; bit ok;
        do_req(1'b1, 22'h000013, 4, 1'b0, ca);
        wait_idle(ok);
        do_req(1'b1, (22'h1 << (MDW + 1)) | 22'h000010, 4, 1'b0, ca);
        wait_idle(ok);
        n_cmp++; if (!ok || pend() != 0) begin
            n_err++; $display("FAIL alias_drain busy=%b pending=%0d required idle, 0 pending", busy_o, pend());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired, required bench to complete");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_beat_gap();
        test_reset_mid_write();
        test_alias();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_burst_responder.md
# mem_burst_responder

Memory-side responder for the data-cache line-transfer protocol. It accepts one line request at a time (read = line fill, write = dirty-line writeout) and answers with a fixed 4-beat burst from an internal word-addressed backing store. A programmable access latency and read-beat spacing model the off-chip memory behind the cache. It sits at the top level as the memory endpoint of the D-cache in simulation and FPGA builds.

## Interface
- DATA_WIDTH, 32, word width.
- ADDRESS_WIDTH, 22, request address width in 2-byte (halfword) units.
- MEM_DEPTH_WIDTH, 12, log2 of backing-store depth in words.
- LATENCY, 2, idle cycles from request acceptance to first beat. Legal range is ≥1.
- BEAT_GAP, 0, idle cycles inserted between consecutive read beats. Write beats never have gaps.
- i_Clk  in  1  sole clock; all logic on rising edge.
- i_Reset_n  in  1  reset, asynchronous, active-low.
- i_MEM_Valid  in  1  request valid from cache.
- i_MEM_Read_Write_n  in  1  1 = line read, 0 = line write.
- i_MEM_Address  in  ADDRESS_WIDTH  halfword line address.
- i_MEM_Data  in  DATA_WIDTH  write word currently offered by cache.
- o_MEM_Valid  out  1  read beat valid on o_MEM_Data.
- o_MEM_Data_Read  out  1  write beat consumed this cycle.
- o_MEM_Last  out  1  final (4th) beat of the burst.
- o_MEM_Data  out  DATA_WIDTH  read beat data.
- o_Busy  out  1  high whenever state ≠ IDLE.

## Operation
- **Address decode**
  - Word address = i_MEM_Address[ADDRESS_WIDTH-1:1].
  - Line base = word address with the low 2 bits forced to 0. Nonzero low bits in a request are ignored.
  - Store index = (base + beat)[MEM_DEPTH_WIDTH-1:0]. Higher bits alias silently.
- **Request capture**
  - In IDLE, a request is accepted on any edge where i_MEM_Valid = 1.
  - Base and direction are captured at that edge.
  - Later changes on the address and direction inputs are ignored until the burst ends.
- **States**
  - IDLE: on accept, load latency counter = LATENCY, go to WAIT.
  - WAIT: count down. At 1, go to RBEAT (read) or WBEAT (write) with beat = 0.
  - RBEAT: for one cycle drive o_MEM_Valid = 1 and o_MEM_Data = mem[base + beat]. o_MEM_Last = 1 when beat = 3.
    - After beat 3, go to IDLE.
    - Otherwise beat + 1; go to RGAP if BEAT_GAP > 0, else stay in RBEAT.
  - RGAP: hold o_MEM_Valid = 0 for BEAT_GAP cycles, then return to RBEAT.
  - WBEAT: o_MEM_Data_Read = 1 on 4 consecutive cycles.
    - On each such cycle, write i_MEM_Data to mem[base + beat] at the closing edge.
    - o_MEM_Last = 1 on beat 3, then go to IDLE.
- **Back-to-back requests**
  - IDLE samples i_MEM_Valid on the first edge after Last.
  - A cache that keeps Valid high and switches from write to read (writeout followed by fill) is accepted with no dead cycle.
- **Backing store**
  - Contents are zero at time 0.
  - Reset never clears the store.
- o_MEM_Data holds its last value when o_MEM_Valid = 0. Consumers must qualify it with o_MEM_Valid.

## Timing
- All outputs are registered.
- Reset values: o_MEM_Valid = 0, o_MEM_Data_Read = 0, o_MEM_Last = 0, o_MEM_Data = 0, o_Busy = 0; state = IDLE; counters = 0.
- Acceptance edge = A.
  - The first beat is visible in cycle A + LATENCY + 1, counting edge A as cycle boundary 0.
  - Read burst length = 4 + 3·BEAT_GAP cycles.
  - Write burst length = exactly 4 cycles.
- Write data is sampled on the same edge that ends each o_MEM_Data_Read cycle.
  - The cache advances to the next word on that same edge.
  - LATENCY ≥ 1 guarantees word 0 is already registered on i_MEM_Data.
- o_MEM_Last is never asserted without o_MEM_Valid (read) or o_MEM_Data_Read (write) in the same cycle.
- If i_MEM_Valid drops mid-burst, the burst still completes. It is not aborted.
- **Reset mid-burst**
  - Outputs clear immediately (asynchronously) and the state returns to IDLE.
  - Words already written by a partial write burst remain in the store. Unwritten words keep their old values.
- Simultaneous events: none. Only one request is in flight at a time and there is no queuing.

## Structure
- **Shared package `mem_pkg`** holds:
  - READ = 1'b1 and WRITE = 1'b0;
  - BURST_LEN = 4;
  - the state encoding (IDLE, WAIT, RBEAT, RGAP, WBEAT);
  - the line-alignment helper constant (2 low word bits).
- **Sub-module `mem_word_ram`**: single-port array with synchronous write and combinational read, DATA_WIDTH × 2^MEM_DEPTH_WIDTH.
  - The read value is registered into o_MEM_Data by the FSM.
- FSM and counters live in `mem_burst_responder`: latency counter (sized to LATENCY), 2-bit beat counter, gap counter.

## Test plan
- **Write burst:** reset, then request write at i_MEM_Address = 0x000010 with i_MEM_Data stepping 0xA0..0xA3 one word per Data_Read beat. Expect Data_Read high on cycles A+3..A+6 (LATENCY = 2), Last on A+6, store words 8..11 = 0xA0..0xA3.
- **Read burst:** read at 0x000010 with BEAT_GAP = 0. Expect Valid on 4 consecutive cycles starting A+3, data 0xA0, 0xA1, 0xA2, 0xA3, Last with 0xA3, o_Busy low on the following cycle.
- **Back-to-back:** write at 0x000020 with 0xB0..0xB3, then Valid held high and direction switched to read at the Last edge. Expect the read accepted on the first IDLE edge and returning 0xB0..0xB3.
- **Beat gap:** BEAT_GAP = 2, read at 0x000010. Expect Valid pulses 3 cycles apart (cycles A+3, A+6, A+9, A+12), Valid low in between, Last only on the 4th pulse.
- **Reset mid-write:** assert i_Reset_n = 0 after 2 write beats of 0xC0, 0xC1 to 0x000030. Expect all outputs 0 immediately. After release, read 0x000030 returns 0xC0, 0xC1, 0, 0.
- **Alias and alignment:** read at 0x000013 and at (1 << (MEM_DEPTH_WIDTH+1)) | 0x10. Both return the same data as 0x000010.
